mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Pipeline MEM stage plus MEM/WB register for the 5-stage RV32I core. It takes EX/MEM fields, runs loads and stores against the data memory over a req/ack handshake, and extracts and extends load data. It stalls the front of the pipe while an access is outstanding, then registers the results the writeback mux consumes: memData_Out_MEMWB, read_Address_MEMWB, PC_plus4_MEMWB and mem2reg_MEMWB.

Parameters:
TIMEOUT_CYCLES, 255, maximum WAIT cycles before the access is abandoned; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_EXMEM  in  1  EX/MEM slot holds a real instruction
alu_result_EXMEM  in  32  byte address, or ALU result for non-memory ops
rs2_data_EXMEM  in  32  store data
PC_plus4_EXMEM  in  32  PC+4 of the instruction
mem2reg_EXMEM  in  2  writeback select, passed through
memRead_EXMEM / memWrite_EXMEM  in  1 each  load / store
funct3_EXMEM  in  3  access size and sign
regWrite_EXMEM  in  1  register write enable
rd_EXMEM  in  5  destination register
dmem_req  out  1  one-cycle request strobe
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, bits [1:0] = 0
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  access complete; dmem_rdata is valid on the ack cycle
dmem_rdata  in  32  read word
stall_MEM  out  1  hold PC, IF/ID, ID/EX and EX/MEM
dmem_timeout  out  1  one-cycle pulse when an access is abandoned
memData_Out_MEMWB  out  32  extended load data
read_Address_MEMWB  out  32  ALU result / address
PC_plus4_MEMWB  out  32
mem2reg_MEMWB  out  2
regWrite_MEMWB  out  1
rd_MEMWB  out  5
valid_MEMWB  out  1

Behaviour:
- Reset: state IDLE and timeout counter 0. Every MEM/WB output is 0. dmem_req, stall_MEM and dmem_timeout are 0.
- acc = valid_EXMEM & (memRead_EXMEM | memWrite_EXMEM). Both read and write set is treated as a store.
- Two states, IDLE and WAIT.
- IDLE, acc=0:
  - MEM/WB loads the EX/MEM fields at the clock edge; memData_Out_MEMWB = 0.
  - Latency is 1 cycle. No stall.
- IDLE, acc=1:
  - dmem_req=1 combinationally. dmem_we = memWrite_EXMEM. dmem_addr = {addr[31:2],2'b00}.
  - stall_MEM=1. Next state WAIT, counter cleared.
  - MEM/WB takes a bubble: valid and regWrite 0, other fields hold.
- Bus fields are meaningful only while dmem_req=1. EX/MEM is held stable by the stall.
- WAIT:
  - dmem_req=0.
  - While ack=0: stall_MEM=1, counter increments, MEM/WB takes bubbles.
  - On the ack cycle: stall_MEM=0, MEM/WB loads EX/MEM fields plus extracted load data, next state IDLE.
  - Minimum access latency is 2 cycles, request to MEM/WB update.
- dmem_ack is ignored in IDLE, including an ack on the request cycle.
- Timeout: when the counter reaches TIMEOUT_CYCLES without ack:
  - dmem_timeout pulses and stall_MEM drops for that cycle.
  - MEM/WB gets the instruction with regWrite forced to 0. State returns to IDLE.
- Store lanes, with a = addr[1:0]:
  - SB (000): be = 4'b0001<<a; wdata = {4{rs2[7:0]}}.
  - SH (001): be = 4'b0011<<{a[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW (010): be = 4'b1111; wdata = rs2.
- Loads set be=4'b1111.
- Load extract: byte = rdata >> (8*a); half = rdata >> (16*a[1]).
  - LB (000) and LH (001) sign-extend. LBU (100) and LHU (101) zero-extend. LW (010) is the full word.
  - Undefined funct3 gives the full word.
- Stores write memData_Out_MEMWB = 0.
- Reset asserted mid-WAIT: immediate return to IDLE with all outputs cleared. An ack arriving later lands in IDLE and is ignored.

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means LH/LHU/SH with a[0]=1, or LW/SW with a≠0.
  - A misaligned access never raises dmem_req and gets no stall.
  - MEM/WB loads the instruction in 1 cycle with regWrite_MEMWB=0.
  - Extra output misalign_MEM pulses 1 for that cycle.
- Undefined: no misalign_MEM port. Low address bits select lanes as above (halves by a[1], words ignore a). Accesses always go to memory.

Test Plan:
- Reset mid-WAIT: assert rst_n=0 during WAIT, dmem_ack=1 one cycle after release -> all outputs 0, state IDLE, no MEM/WB update.
- ADD, alu_result=0x10, PC+4=0x24 -> next cycle read_Address_MEMWB=0x10, PC_plus4_MEMWB=0x24, valid_MEMWB=1, stall_MEM never asserted.
- LB at 0x1003, rdata=0x80FF1234, ack 3 cycles after req -> one dmem_req pulse, addr 0x1000, stall_MEM high 3 cycles, memData_Out_MEMWB=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at 0x2002, rs2=0xABCD1234 -> be=4'b1100, wdata=0x12341234, we=1, regWrite_MEMWB=0.
- TIMEOUT_CYCLES=4, no ack -> dmem_timeout pulse in the 4th WAIT cycle, regWrite_MEMWB=0, state IDLE; a following ADD completes normally.
- With MEM_MISALIGN_TRAP_EN: LW at 0x1001 -> no dmem_req, misalign_MEM=1 for one cycle, regWrite_MEMWB=0. Without the macro: req issued to addr 0x1000, full word loaded.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM stage + MEM/WB register: drives data-memory req/ack, lane-steers stores, extends loads; MEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Latency: 1 cycle for non-memory ops, >= 2 cycles request-to-MEM/WB for loads/stores (ack-dependent, bounded by TIMEOUT_CYCLES).
// Backpressure: stall_MEM holds the front of the pipe while an access is outstanding; MEM/WB takes bubbles meanwhile.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_EXMEM,
    input  logic [31:0] alu_result_EXMEM,
    input  logic [31:0] rs2_data_EXMEM,
    input  logic [31:0] PC_plus4_EXMEM,
    input  logic [1:0]  mem2reg_EXMEM,
    input  logic        memRead_EXMEM,
    input  logic        memWrite_EXMEM,
    input  logic [2:0]  funct3_EXMEM,
    input  logic        regWrite_EXMEM,
    input  logic [4:0]  rd_EXMEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_MEM,
    output logic        dmem_timeout,
    output logic [31:0] memData_Out_MEMWB,
    output logic [31:0] read_Address_MEMWB,
    output logic [31:0] PC_plus4_MEMWB,
    output logic [1:0]  mem2reg_MEMWB,
    output logic        regWrite_MEMWB,
    output logic [4:0]  rd_MEMWB,
    output logic        valid_MEMWB
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_MEM
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [1:0]  a;
    logic        acc, misal, timeout_hit;
    logic        req, stall, tout, mis, upd, bub, no_wr, take_data;
    logic [31:0] byte_sh, half_sh, ld_data;

    assign a   = alu_result_EXMEM[1:0];
    assign acc = valid_EXMEM & (memRead_EXMEM | memWrite_EXMEM);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misal = (((funct3_EXMEM == 3'b001) || (funct3_EXMEM == 3'b101)) && a[0])
                 || ((funct3_EXMEM == 3'b010) && (a != 2'b00));
`else
    assign misal = 1'b0;
`endif

    // The counter value is the number of WAIT cycles already spent without ack.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = 1'b0;
        stall     = 1'b0;
        tout      = 1'b0;
        mis       = 1'b0;
        upd       = 1'b0;
        bub       = 1'b0;
        no_wr     = 1'b0;
        take_data = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc && !misal) begin
                    req       = 1'b1;
                    stall     = 1'b1;
                    bub       = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end else begin
                    upd   = 1'b1;
                    mis   = acc;
                    no_wr = acc;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    upd       = 1'b1;
                    take_data = memRead_EXMEM & ~memWrite_EXMEM;
                    state_nxt = S_IDLE;
                end else if (timeout_hit) begin
                    tout      = 1'b1;
                    upd       = 1'b1;
                    no_wr     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stall   = 1'b1;
                    bub     = 1'b1;
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Combinational strobes are masked so they read 0 while reset is held.
    assign dmem_req     = req & rst_n;
    assign stall_MEM    = stall & rst_n;
    assign dmem_timeout = tout & rst_n;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_MEM = mis & rst_n;
`endif

    assign dmem_we   = memWrite_EXMEM;
    assign dmem_addr = {alu_result_EXMEM[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = rs2_data_EXMEM;
        if (memWrite_EXMEM) begin
            case (funct3_EXMEM)
                3'b000: begin
                    dmem_be    = 4'b0001 << a;
                    dmem_wdata = {4{rs2_data_EXMEM[7:0]}};
                end
                3'b001: begin
                    dmem_be    = 4'b0011 << {a[1], 1'b0};
                    dmem_wdata = {2{rs2_data_EXMEM[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = rs2_data_EXMEM;
                end
            endcase
        end
    end

    assign byte_sh = dmem_rdata >> {a, 3'b000};
    assign half_sh = dmem_rdata >> {a[1], 4'b0000};

    always_comb begin
        ld_data = dmem_rdata;
        case (funct3_EXMEM)
            3'b000:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b100:  ld_data = {24'd0, byte_sh[7:0]};
            3'b101:  ld_data = {16'd0, half_sh[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memData_Out_MEMWB  <= '0;
            read_Address_MEMWB <= '0;
            PC_plus4_MEMWB     <= '0;
            mem2reg_MEMWB      <= '0;
            regWrite_MEMWB     <= 1'b0;
            rd_MEMWB           <= '0;
            valid_MEMWB        <= 1'b0;
        end else if (upd) begin
            memData_Out_MEMWB  <= take_data ? ld_data : 32'd0;
            read_Address_MEMWB <= alu_result_EXMEM;
            PC_plus4_MEMWB     <= PC_plus4_EXMEM;
            mem2reg_MEMWB      <= mem2reg_EXMEM;
            regWrite_MEMWB     <= regWrite_EXMEM & ~no_wr;
            rd_MEMWB           <= rd_EXMEM;
            valid_MEMWB        <= valid_EXMEM;
        end else if (bub) begin
            regWrite_MEMWB <= 1'b0;
            valid_MEMWB    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed test-plan cases plus randomized instruction stream against a transaction-level model.
module tb_mem_stage_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_EXMEM, memRead_EXMEM, memWrite_EXMEM, regWrite_EXMEM;
    logic [31:0] alu_result_EXMEM, rs2_data_EXMEM, PC_plus4_EXMEM;
    logic [1:0]  mem2reg_EXMEM;
    logic [2:0]  funct3_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic        dmem_req, dmem_we, dmem_ack, stall_MEM, dmem_timeout;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] memData_Out_MEMWB, read_Address_MEMWB, PC_plus4_MEMWB;
    logic [1:0]  mem2reg_MEMWB;
    logic        regWrite_MEMWB, valid_MEMWB;
    logic [4:0]  rd_MEMWB;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_MEM;
`endif

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_EXMEM(valid_EXMEM),
        .alu_result_EXMEM(alu_result_EXMEM), .rs2_data_EXMEM(rs2_data_EXMEM),
        .PC_plus4_EXMEM(PC_plus4_EXMEM), .mem2reg_EXMEM(mem2reg_EXMEM),
        .memRead_EXMEM(memRead_EXMEM), .memWrite_EXMEM(memWrite_EXMEM),
        .funct3_EXMEM(funct3_EXMEM), .regWrite_EXMEM(regWrite_EXMEM), .rd_EXMEM(rd_EXMEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_MEM(stall_MEM), .dmem_timeout(dmem_timeout),
        .memData_Out_MEMWB(memData_Out_MEMWB), .read_Address_MEMWB(read_Address_MEMWB),
        .PC_plus4_MEMWB(PC_plus4_MEMWB), .mem2reg_MEMWB(mem2reg_MEMWB),
        .regWrite_MEMWB(regWrite_MEMWB), .rd_MEMWB(rd_MEMWB), .valid_MEMWB(valid_MEMWB)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_MEM(misalign_MEM)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Expected per-cycle bus/stall behaviour and expected MEM/WB contents.
    logic        e_req = 0, e_we = 0, e_stall = 0, e_to = 0, e_chk_wdata = 0;
    logic [31:0] e_addr = 0, e_wdata = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] m_data = 0, m_addr = 0, m_pc = 0;
    logic [1:0]  m_m2r = 0;
    logic        m_rw = 0, m_vld = 0;
    logic [4:0]  m_rd = 0;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    int          stall_cycles, to_pulses, req_pulses;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
        chk("stall_MEM", {31'd0, stall_MEM}, {31'd0, e_stall});
        chk("dmem_timeout", {31'd0, dmem_timeout}, {31'd0, e_to});
        chk("memData_MEMWB", memData_Out_MEMWB, m_data);
        chk("readAddr_MEMWB", read_Address_MEMWB, m_addr);
        chk("PC_plus4_MEMWB", PC_plus4_MEMWB, m_pc);
        chk("mem2reg_MEMWB", {30'd0, mem2reg_MEMWB}, {30'd0, m_m2r});
        chk("regWrite_MEMWB", {31'd0, regWrite_MEMWB}, {31'd0, m_rw});
        chk("rd_MEMWB", {27'd0, rd_MEMWB}, {27'd0, m_rd});
        chk("valid_MEMWB", {31'd0, valid_MEMWB}, {31'd0, m_vld});
        if (e_req) begin
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
            chk("dmem_addr", dmem_addr, e_addr);
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
            if (e_chk_wdata) chk("dmem_wdata", dmem_wdata, e_wdata);
        end
        if (dmem_req) begin
            cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
            req_pulses++;
        end
        if (stall_MEM) stall_cycles++;
        if (dmem_timeout) to_pulses++;
    end

    function automatic logic [3:0] model_be(input logic [2:0] f3, input int a, input logic st);
        if (!st) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << a);
        if (f3 == 3'd1) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] v);
        if (f3 == 3'd0) return (v & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (v & 32'hFFFF) * 32'h00010001;
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic vld, input logic rd_, input logic wr_, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                             input logic rw, input logic [4:0] rd, input logic [1:0] m2r,
                             input int ack_delay, input logic ack_req, input logic [31:0] rdata_ack);
        logic timed;
        int   last;
        valid_EXMEM = vld; memRead_EXMEM = rd_; memWrite_EXMEM = wr_; funct3_EXMEM = f3;
        alu_result_EXMEM = alu; rs2_data_EXMEM = rs2; PC_plus4_EXMEM = pc;
        regWrite_EXMEM = rw; rd_EXMEM = rd; mem2reg_EXMEM = m2r;
        e_to = 0;
        if (!(vld && (rd_ || wr_))) begin
            dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
            e_req = 0; e_stall = 0;
            step();
            m_data = 0; m_addr = alu; m_pc = pc; m_m2r = m2r; m_rw = rw; m_rd = rd; m_vld = vld;
        end else begin
            e_req = 1; e_we = wr_; e_addr = alu & 32'hFFFF_FFFC;
            e_be = model_be(f3, int'(alu % 4), wr_); e_wdata = model_wdata(f3, rs2);
            e_chk_wdata = wr_; e_stall = 1;
            dmem_ack = ack_req; dmem_rdata = $urandom;
            step();
            m_vld = 0; m_rw = 0; e_req = 0;
            timed = (ack_delay > TO);
            last = timed ? TO : ack_delay;
            for (int k = 1; k <= last; k++) begin
                dmem_ack   = (k == ack_delay);
                dmem_rdata = (k == last) ? rdata_ack : $urandom;
                e_stall    = (k != last);
                e_to       = timed && (k == last);
                step();
                e_to = 0;
                if (k == last) begin
                    m_data = (timed || wr_) ? 32'd0 : model_load(f3, int'(alu % 4), rdata_ack);
                    m_addr = alu; m_pc = pc; m_m2r = m2r; m_rd = rd; m_vld = vld;
                    m_rw = timed ? 1'b0 : rw;
                end
            end
            e_stall = 0;
        end
    endtask

    task automatic park();
        valid_EXMEM = 0; memRead_EXMEM = 0; memWrite_EXMEM = 0; funct3_EXMEM = 0;
        alu_result_EXMEM = 0; rs2_data_EXMEM = 0; PC_plus4_EXMEM = 0;
        regWrite_EXMEM = 0; rd_EXMEM = 0; mem2reg_EXMEM = 0; dmem_ack = 0;
        e_req = 0; e_stall = 0; e_to = 0;
        @(negedge clk);
    endtask

    task automatic unpark();
        step();
        m_data = 0; m_addr = 0; m_pc = 0; m_m2r = 0; m_rw = 0; m_rd = 0; m_vld = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       vld, rd_, wr_;
        logic [2:0] f3;
        int         kind;
        rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
        valid_EXMEM = 1; memRead_EXMEM = 1; memWrite_EXMEM = 0; funct3_EXMEM = 3'd2;
        alu_result_EXMEM = 32'h40; rs2_data_EXMEM = 0; PC_plus4_EXMEM = 32'h8;
        regWrite_EXMEM = 1; rd_EXMEM = 5'd3; mem2reg_EXMEM = 2'd1;
        step(); step();
        rst_n = 1;

        // ADD
        stall_cycles = 0;
        run_instr(1, 0, 0, 3'd0, 32'h10, 32'h0, 32'h24, 1, 5'd7, 2'd0, 1, 0, 0);
        park();
        chk("add_addr", read_Address_MEMWB, 32'h10);
        chk("add_pc4", PC_plus4_MEMWB, 32'h24);
        chk("add_valid", {31'd0, valid_MEMWB}, 32'd1);
        chk("add_nostall", stall_cycles, 0);
        unpark();

        // LB / LBU at 0x1003, ack 3 cycles after req
        stall_cycles = 0; req_pulses = 0;
        run_instr(1, 1, 0, 3'd0, 32'h1003, 0, 32'h104, 1, 5'd9, 2'd1, 3, 0, 32'h80FF1234);
        park();
        chk("lb_data", memData_Out_MEMWB, 32'hFFFFFF80);
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_stall_cycles", stall_cycles, 3);
        chk("lb_req_pulses", req_pulses, 1);
        unpark();
        run_instr(1, 1, 0, 3'd4, 32'h1003, 0, 32'h108, 1, 5'd9, 2'd1, 3, 0, 32'h80FF1234);
        park();
        chk("lbu_data", memData_Out_MEMWB, 32'h00000080);
        unpark();

        // SH at 0x2002
        run_instr(1, 0, 1, 3'd1, 32'h2002, 32'hABCD1234, 32'h10C, 0, 5'd0, 2'd0, 1, 1, 32'h5555_5555);
        park();
        chk("sh_be", {28'd0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'h12341234);
        chk("sh_we", {31'd0, cap_we}, 32'd1);
        chk("sh_regwrite", {31'd0, regWrite_MEMWB}, 32'd0);
        unpark();

        // Timeout, then a normal ADD
        to_pulses = 0;
        run_instr(1, 1, 0, 3'd2, 32'h3000, 0, 32'h110, 1, 5'd4, 2'd1, 99, 0, 0);
        park();
        chk("to_pulses", to_pulses, 1);
        chk("to_regwrite", {31'd0, regWrite_MEMWB}, 32'd0);
        chk("to_addr", read_Address_MEMWB, 32'h3000);
        unpark();
        run_instr(1, 0, 0, 3'd0, 32'h77, 0, 32'h114, 1, 5'd8, 2'd0, 1, 0, 0);
        park();
        chk("post_to_valid", {31'd0, valid_MEMWB}, 32'd1);
        chk("post_to_addr", read_Address_MEMWB, 32'h77);
        unpark();

`ifndef MEM_MISALIGN_TRAP_EN
        // Misaligned LW goes to memory with the low bits dropped
        run_instr(1, 1, 0, 3'd2, 32'h1001, 0, 32'h118, 1, 5'd6, 2'd1, 1, 0, 32'hDEADBEEF);
        park();
        chk("lw_mis_addr", cap_addr, 32'h1000);
        chk("lw_mis_data", memData_Out_MEMWB, 32'hDEADBEEF);
        unpark();
`endif

        // Reset asserted in WAIT; the later ack must not complete anything
        valid_EXMEM = 1; memRead_EXMEM = 1; memWrite_EXMEM = 0; funct3_EXMEM = 3'd2;
        alu_result_EXMEM = 32'h500; PC_plus4_EXMEM = 32'h200; regWrite_EXMEM = 1;
        rd_EXMEM = 5'd11; mem2reg_EXMEM = 2'd1; dmem_ack = 0;
        e_req = 1; e_we = 0; e_addr = 32'h500; e_be = 4'hF; e_chk_wdata = 0; e_stall = 1;
        step();
        m_vld = 0; m_rw = 0; e_req = 0;
        step();
        #3 rst_n = 0;
        e_stall = 0; e_req = 0;
        m_data = 0; m_addr = 0; m_pc = 0; m_m2r = 0; m_rw = 0; m_rd = 0; m_vld = 0;
        step();
        rst_n = 1;
        run_instr(1, 1, 0, 3'd2, 32'h500, 0, 32'h200, 1, 5'd11, 2'd1, 2, 1, 32'hCAFE0001);

        // Randomized stream
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom % 4);
            vld  = ($urandom % 8) != 0;
            rd_  = (kind == 1) || (kind == 3);
            wr_  = (kind == 2) || (kind == 3);
            if (kind == 0) rd_ = ($urandom % 4) == 0 && !vld;
            f3 = wr_ ? 3'($urandom % 3) : 3'($urandom % 8);
            run_instr(vld, rd_, wr_, f3, $urandom, $urandom, $urandom, 1'($urandom % 2),
                      5'($urandom), 2'($urandom), $urandom_range(1, 6), 1'($urandom % 2), $urandom);
        end
        park();
        unpark();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
